pe_loader: RTL and testbench

PE_LOADER -- requirements
Module: pe_loader

---
 rtl/pe_loader_pkg.sv | 27 ++
 rtl/pe_latency_timer.sv | 28 ++
 rtl/pe_loader.sv | 137 +++++++++++++
 tb/tb_pe_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_loader_pkg.sv
// Shared definitions for the PE tile loader: FSM encoding and the
// width helpers used to size the tile and result buses.
package pe_loader_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } pe_state_e;

    localparam int DEF_MESH_X  = 8;
    localparam int DEF_MESH_Y  = 8;
    localparam int DEF_IN_BIT  = 8;
    localparam int DEF_OUT_BIT = 32;
    localparam int DEF_TILE_W  = DEF_MESH_X * DEF_MESH_Y * DEF_IN_BIT;
    localparam int DEF_RES_W   = DEF_MESH_X * DEF_MESH_Y * DEF_OUT_BIT;

    function automatic int tile_width(input int mesh_x, input int mesh_y, input int in_bit);
        return mesh_x * mesh_y * in_bit;
    endfunction

    function automatic int result_width(input int mesh_x, input int mesh_y, input int out_bit);
        return mesh_x * mesh_y * out_bit;
    endfunction

endpackage

// File: rtl/pe_latency_timer.sv
// Counts the PE pipeline latency after an issue; done is high on the
// last cycle of the wait window (count == 1).
module pe_latency_timer #(
    parameter int LATENCY = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(LATENCY + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CW'(LATENCY);
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == CW'(1));

endmodule

// File: rtl/pe_loader.sv
// Gathers MESH_N tiles/weights into one PE issue, supplies the partial sum,
// waits out the PE latency, and accumulates or emits the result.
module pe_loader
    import pe_loader_pkg::*;
#(
    parameter int IN_BIT     = 8,
    parameter int WEIGHT_BIT = 8,
    parameter int OUT_BIT    = 32,
    parameter int MESH_X     = 8,
    parameter int MESH_Y     = 8,
    parameter int MESH_N     = 64,
    parameter int PE_LATENCY = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    input  logic [MESH_X*MESH_Y*IN_BIT-1:0]           s_tile,
    input  logic [WEIGHT_BIT-1:0]                     s_weight,
    input  logic                                      s_first,
    input  logic                                      s_last,
    output logic                                      pe_ena,
    output logic                                      pe_data_valid,
    output logic [MESH_N*MESH_X*MESH_Y*IN_BIT-1:0]    pe_data_in,
    output logic [MESH_N*WEIGHT_BIT-1:0]              pe_weight,
    output logic [MESH_X*MESH_Y*OUT_BIT-1:0]          pe_inter_data,
    input  logic [MESH_X*MESH_Y*OUT_BIT-1:0]          pe_data_out,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [MESH_X*MESH_Y*OUT_BIT-1:0]          m_data,
    output logic                                      busy
);

    localparam int TILE_W = tile_width(MESH_X, MESH_Y, IN_BIT);
    localparam int RES_W  = result_width(MESH_X, MESH_Y, OUT_BIT);
    localparam int CNT_W  = (MESH_N > 1) ? $clog2(MESH_N) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MESH_N - 1);

    // Both stream ports use valid/ready: a beat transfers on the rising edge
    // where valid & ready are both high; the sender holds data until then.

    pe_state_e                    state_q, state_d;
    logic [CNT_W-1:0]             tile_cnt_q;
    logic [MESH_N*TILE_W-1:0]     data_in_q;
    logic [MESH_N*WEIGHT_BIT-1:0] weight_q;
    logic [RES_W-1:0]             acc_q;
    logic                         first_q;
    logic                         last_q;
    logic                         beat_acc;
    logic                         timer_done;

    assign s_ready  = (state_q == ST_FILL);
    assign beat_acc = s_valid & s_ready;

    pe_latency_timer #(
        .LATENCY(PE_LATENCY)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (state_q == ST_ISSUE),
        .done (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pe_ena        = 1'b0;
        pe_data_valid = 1'b0;
        m_valid       = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (beat_acc && (tile_cnt_q == LAST_BEAT)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pe_ena        = 1'b1;
                pe_data_valid = 1'b1;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                pe_ena = 1'b1;
                if (timer_done) begin
                    state_d = last_q ? ST_OUT : ST_FILL;
                end
            end
            ST_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Group flags are taken from beat 0 only; later beats cannot change them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_cnt_q <= '0;
            data_in_q  <= '0;
            weight_q   <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
        end else if (beat_acc) begin
            data_in_q[int'(tile_cnt_q)*TILE_W +: TILE_W]        <= s_tile;
            weight_q[int'(tile_cnt_q)*WEIGHT_BIT +: WEIGHT_BIT] <= s_weight;
            tile_cnt_q <= (tile_cnt_q == LAST_BEAT) ? '0 : tile_cnt_q + 1'b1;
            if (tile_cnt_q == '0) begin
                first_q <= s_first;
                last_q  <= s_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if ((state_q == ST_WAIT) && timer_done) begin
            acc_q <= pe_data_out;
        end
    end

    assign pe_data_in    = data_in_q;
    assign pe_weight     = weight_q;
    assign pe_inter_data = first_q ? '0 : acc_q;
    assign m_data        = acc_q;
    assign busy          = (state_q != ST_FILL) || (tile_cnt_q != '0);

endmodule

// File: tb/tb_pe_loader.sv
// Bench for pe_loader with a 1x1 mesh, 4 tiles per group and a 3-cycle PE model.
module tb_pe_loader;

  localparam int MX  = 1;
  localparam int MY  = 1;
  localparam int MN  = 4;
  localparam int IB  = 8;
  localparam int WB  = 8;
  localparam int OB  = 32;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_tile;
  logic [7:0]  s_weight;
  logic        s_first;
  logic        s_last;
  logic        pe_ena;
  logic        pe_data_valid;
  logic [31:0] pe_data_in;
  logic [31:0] pe_weight;
  logic [31:0] pe_inter_data;
  logic [31:0] pe_data_out;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        busy;

  pe_loader #(
    .IN_BIT(IB), .WEIGHT_BIT(WB), .OUT_BIT(OB), .MESH_X(MX), .MESH_Y(MY),
    .MESH_N(MN), .PE_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_tile(s_tile), .s_weight(s_weight), .s_first(s_first), .s_last(s_last),
    .pe_ena(pe_ena), .pe_data_valid(pe_data_valid), .pe_data_in(pe_data_in),
    .pe_weight(pe_weight), .pe_inter_data(pe_inter_data), .pe_data_out(pe_data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] acc_model = 32'd0;

  function automatic logic [31:0] dot4(input logic [31:0] d, input logic [31:0] w);
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < MN; k++) s += 32'(d[k*8 +: 8]) * 32'(w[k*8 +: 8]);
    return s;
  endfunction

  // behavioural PE: result of an issue appears LAT cycles later, garbage otherwise
  logic [31:0] pe_pipe [LAT];
  always @(posedge clk) begin
    pe_pipe[0] <= pe_data_valid ? dot4(pe_data_in, pe_weight) + pe_inter_data : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
  end
  assign pe_data_out = pe_pipe[LAT-1];

  // monitors
  int cyc = 0;
  int accept_cyc = 0;
  int issue_cyc = -1;
  int issue_cnt = 0;
  int ena_cnt = 0;
  logic [31:0] mon_inter, mon_din, mon_w;

  always @(posedge clk) begin
    cyc++;
    if (s_valid && s_ready) accept_cyc = cyc;
  end

  always @(negedge clk) begin
    if (pe_ena) ena_cnt++;
    if (pe_data_valid) begin
      issue_cnt++;
      issue_cyc = cyc;
      mon_inter = pe_inter_data;
      mon_din   = pe_data_in;
      mon_w     = pe_weight;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT, got 0 expected 1", name);
  endtask

  // driver
  task automatic send_beat(input logic [7:0] t, input logic [7:0] w, input bit f, input bit l);
    int g;
    s_valid = 1'b1; s_tile = t; s_weight = w; s_first = f; s_last = l;
    g = 0;
    while (!s_ready && g < 100) begin step(); g++; end
    if (g >= 100) timeout("s_ready");
    step();
    s_valid = 1'b0;
    s_first = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_group(input logic [31:0] tiles, input logic [31:0] weights,
                          input bit first, input bit last, input bit force_stray,
                          input int gap, input int hold,
                          output logic [31:0] got_inter, output logic [31:0] got_m);
    int i0, e0, g;
    bit f, l;
    logic [31:0] exp_inter, exp_m;
    exp_inter = first ? 32'd0 : acc_model;
    acc_model = exp_inter + dot4(tiles, weights);
    if (last) exp_q.push_back(acc_model);
    i0 = issue_cnt;
    e0 = ena_cnt;
    got_m = 32'd0;
    for (int k = 0; k < MN; k++) begin
      f = (k == 0) ? first : (force_stray ? 1'b1 : 1'($urandom_range(0, 1)));
      l = (k == 0) ? last  : 1'($urandom_range(0, 1));
      send_beat(tiles[k*8 +: 8], weights[k*8 +: 8], f, l);
      repeat (gap) step();
    end
    g = 0;
    if (last) begin
      while (!m_valid && g < 50) begin step(); g++; end
    end else begin
      while (busy && g < 50) begin step(); g++; end
    end
    if (g >= 50) timeout("group_done");
    check("issue_pulses", 32'(issue_cnt - i0), 32'd1);
    check("pe_ena_cycles", 32'(ena_cnt - e0), 32'(LAT + 1));
    check("pe_data_in", mon_din, tiles);
    check("pe_weight", mon_w, weights);
    check("pe_inter_data", mon_inter, exp_inter);
    got_inter = mon_inter;
    if (last) begin
      exp_m = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      got_m = m_data;
      check("m_data", m_data, exp_m);
      m_ready = 1'b0;
      repeat (hold) begin
        step();
        check("hold_m_valid", 32'(m_valid), 32'd1);
        check("hold_m_data", m_data, exp_m);
        check("hold_s_ready", 32'(s_ready), 32'd0);
        check("hold_pe_ena", 32'(pe_ena), 32'd0);
      end
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("m_valid_after_hs", 32'(m_valid), 32'd0);
      check("s_ready_after_hs", 32'(s_ready), 32'd1);
    end
  endtask

  typedef struct {
    logic [31:0] tiles;
    logic [31:0] weights;
    bit          first;
    bit          last;
    logic [31:0] exp_inter;
    logic [31:0] exp_m;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [31:0] gi, gm;
    int g;
    // tiles/weights are packed with beat 0 in the low byte
    tbl[0] = '{32'h04030201, 32'h01010101, 1'b1, 1'b1, 32'd0,      32'd10};
    tbl[1] = '{32'h04030201, 32'h01010101, 1'b1, 1'b0, 32'd0,      32'd0};
    tbl[2] = '{32'h04030201, 32'h01010101, 1'b0, 1'b1, 32'd10,     32'd20};
    tbl[3] = '{32'h08070605, 32'h03010002, 1'b1, 1'b1, 32'd0,      32'd41};
    tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd0,      32'd0};
    tbl[5] = '{32'h01000000, 32'h01000000, 1'b0, 1'b1, 32'd260100, 32'd260101};

    rst_n = 1'b0; s_valid = 1'b0; s_tile = '0; s_weight = '0;
    s_first = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_pe_ena", 32'(pe_ena), 32'd0);
    check("rst_pe_data_valid", 32'(pe_data_valid), 32'd0);
    check("rst_pe_data_in", pe_data_in, 32'd0);
    check("rst_pe_weight", pe_weight, 32'd0);
    check("rst_pe_inter_data", pe_inter_data, 32'd0);
    check("rst_m_data", m_data, 32'd0);

    // table-driven groups
    for (int i = 0; i < 6; i++) begin
      do_group(tbl[i].tiles, tbl[i].weights, tbl[i].first, tbl[i].last, 1'b0, 0, 1, gi, gm);
      check("tbl_inter", gi, tbl[i].exp_inter);
      if (tbl[i].last) check("tbl_m_data", gm, tbl[i].exp_m);
    end

    // output held while m_ready stays low
    do_group(32'h04030201, 32'h01010101, 1'b1, 1'b1, 1'b0, 0, 5, gi, gm);
    check("hold5_m_data", gm, 32'd10);

    // first asserted only on a non-zero beat is ignored
    do_group(32'h04030201, 32'h01010101, 1'b0, 1'b1, 1'b1, 0, 0, gi, gm);
    check("stray_first_inter", gi, 32'd10);
    check("stray_first_m", gm, 32'd20);

    // reset while waiting on the PE: result in flight is dropped
    do_group(32'h09090909, 32'h01010101, 1'b1, 1'b0, 1'b0, 0, 0, gi, gm);
    for (int k = 0; k < MN; k++) send_beat(8'd5, 8'd1, (k == 0) ? 1'b0 : 1'b1, 1'b1);
    g = 0;
    while (!pe_data_valid && g < 20) begin step(); g++; end
    if (g >= 20) timeout("issue_before_reset");
    step();
    check("wait_pe_ena", 32'(pe_ena), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midwait_rst_pe_ena", 32'(pe_ena), 32'd0);
    check("midwait_rst_busy", 32'(busy), 32'd0);
    check("midwait_rst_m_data", m_data, 32'd0);
    check("midwait_rst_inter", pe_inter_data, 32'd0);
    check("midwait_rst_data_in", pe_data_in, 32'd0);
    step();
    rst_n = 1'b1;
    acc_model = 32'd0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("midwait_no_m_valid", 32'(m_valid), 32'd0);
    end
    check("midwait_acc_cleared", m_data, 32'd0);
    do_group(32'h04030201, 32'h01010101, 1'b0, 1'b1, 1'b0, 0, 0, gi, gm);
    check("post_rst_inter", gi, 32'd0);
    check("post_rst_m", gm, 32'd10);

    // s_valid toggling every other cycle
    do_group(32'h44332211, 32'h02020202, 1'b1, 1'b1, 1'b0, 1, 0, gi, gm);
    check("toggle_issue_timing", 32'(issue_cyc), 32'(accept_cyc));

    // randomized groups against the model
    for (int i = 0; i < 25; i++) begin
      do_group($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'b0, $urandom_range(0, 2), $urandom_range(0, 3), gi, gm);
    end
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit, got 0 expected 1");
    $fatal(1);
  end

endmodule
